// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back stage: load-size encodings,
// the zero-register index, datapath widths and the stage-register layout.
package wb_pkg;
  localparam int DATA_W = 64;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 32;

  localparam logic [REG_W-1:0] XZR_INDEX = 5'd31;

  typedef enum logic [1:0] {
    LS_BYTE  = 2'b00,
    LS_HALF  = 2'b01,
    LS_WORD  = 2'b10,
    LS_DWORD = 2'b11
  } load_size_e;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              misalign;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_state_t;
endpackage

// File: rtl/load_align.sv
// Combinational load lane select: picks the little-endian lane at the byte
// offset, sign/zero-extends it, and flags offsets illegal for the access size.
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]        i_offset,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misalign
);
  logic [DATA_W-1:0] w_shift;
  load_size_e        w_size;

  assign w_size  = load_size_e'(i_size);
  assign w_shift = i_data >> {i_offset, 3'b000};

  always_comb begin
    o_data     = w_shift;
    o_misalign = 1'b0;
    case (w_size)
      LS_BYTE: o_data = {{56{i_signed & w_shift[7]}}, w_shift[7:0]};
      LS_HALF: begin
        o_data     = {{48{i_signed & w_shift[15]}}, w_shift[15:0]};
        o_misalign = i_offset[0];
      end
      LS_WORD: begin
        o_data     = {{32{i_signed & w_shift[31]}}, w_shift[31:0]};
        o_misalign = |i_offset[1:0];
      end
      default: begin
        o_data     = w_shift;
        o_misalign = |i_offset;
      end
    endcase
  end
endmodule

// File: rtl/write_back_stage.sv
// Single-register write-back stage: selects BL/load/ALU data, gates the
// register write, and counts committed writes.
module write_back_stage
  import wb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              RegWrite_in,
  input  logic              MemtoReg,
  input  logic              Branchlink,
  input  logic [1:0]        load_size,
  input  logic              load_signed,
  input  logic [REG_W-1:0]  rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] PC_branch_link_in,
  output logic [DATA_W-1:0] write_back,
  output logic [REG_W-1:0]  Write_register,
  output logic              RegWrite,
  output logic              wb_valid,
  output logic              misalign,
  output logic [CNT_W-1:0]  retire_count
);
  wb_state_t         r_st;
  wb_state_t         w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_load_data;
  logic              w_load_misalign;

  load_align u_load_align (
    .i_offset   (alu_result[2:0]),
    .i_size     (load_size),
    .i_signed   (load_signed),
    .i_data     (mem_read_data),
    .o_data     (w_load_data),
    .o_misalign (w_load_misalign)
  );

  // Alignment only matters when the load data is actually selected.
  always_comb begin
    w_next = '0;
    if (mem_valid) begin
      w_next.valid    = 1'b1;
      w_next.rd       = rd;
      w_next.misalign = MemtoReg && !Branchlink && w_load_misalign;
      w_next.regwrite = RegWrite_in && (rd != XZR_INDEX) && !w_next.misalign;
      if (Branchlink)    w_next.data = PC_branch_link_in;
      else if (MemtoReg) w_next.data = w_load_data;
      else               w_next.data = alu_result;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_st  <= '0;
      r_cnt <= '0;
    end else begin
      if (flush) begin
        r_st.valid    <= 1'b0;
        r_st.regwrite <= 1'b0;
        r_st.misalign <= 1'b0;
      end else if (!stall) begin
        r_st <= w_next;
      end
      if (r_st.regwrite && !stall) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign write_back     = r_st.data;
  assign Write_register = r_st.rd;
  assign RegWrite       = r_st.regwrite;
  assign wb_valid       = r_st.valid;
  assign misalign       = r_st.misalign;
  assign retire_count   = r_cnt;
endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage with hand-computed expectations.
module tb_write_back_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        stall, flush, mem_valid, RegWrite_in, MemtoReg, Branchlink;
  logic [1:0]  load_size;
  logic        load_signed;
  logic [4:0]  rd;
  logic [63:0] alu_result, mem_read_data, PC_branch_link_in;
  logic [63:0] write_back;
  logic [4:0]  Write_register;
  logic        RegWrite, wb_valid, misalign;
  logic [31:0] retire_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  write_back_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .RegWrite_in(RegWrite_in), .MemtoReg(MemtoReg),
    .Branchlink(Branchlink), .load_size(load_size), .load_signed(load_signed),
    .rd(rd), .alu_result(alu_result), .mem_read_data(mem_read_data),
    .PC_branch_link_in(PC_branch_link_in), .write_back(write_back),
    .Write_register(Write_register), .RegWrite(RegWrite), .wb_valid(wb_valid),
    .misalign(misalign), .retire_count(retire_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic bl,
                       input logic [1:0] sz, input logic sg, input logic [4:0] r,
                       input logic [63:0] alu, input logic [63:0] mem, input logic [63:0] pc);
    mem_valid = v; RegWrite_in = rw; MemtoReg = m2r; Branchlink = bl;
    load_size = sz; load_signed = sg; rd = r;
    alu_result = alu; mem_read_data = mem; PC_branch_link_in = pc;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] wb, input logic [4:0] wr,
                         input logic rw, input logic v, input logic ma);
    check({tag, ".wb"},   write_back, wb);
    check({tag, ".wreg"}, 64'(Write_register), 64'(wr));
    check({tag, ".rw"},   64'(RegWrite), 64'(rw));
    check({tag, ".vld"},  64'(wb_valid), 64'(v));
    check({tag, ".mis"},  64'(misalign), 64'(ma));
  endtask

  task automatic chk_ctl(input string tag, input logic rw, input logic v, input logic ma);
    check({tag, ".rw"},  64'(RegWrite), 64'(rw));
    check({tag, ".vld"}, 64'(wb_valid), 64'(v));
    check({tag, ".mis"}, 64'(misalign), 64'(ma));
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] c);
    check({tag, ".cnt"}, 64'(retire_count), 64'(c));
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 0, 2'b00, 0, 5'd0, 64'h0, 64'h0, 64'h0);
    #3;
    chk_out("reset", 64'h0, 5'd0, 0, 0, 0);
    chk_cnt("reset", 32'd0);
    #9 reset = 1'b1;  // released at t=12, between edges

    // ALU write
    drive(1, 1, 0, 0, 2'b00, 0, 5'd5, 64'h1234, 64'h0, 64'h0);
    tick();
    chk_out("alu", 64'h1234, 5'd5, 1, 1, 0);
    chk_cnt("alu", 32'd0);

    // signed byte load, offset 3
    drive(1, 1, 1, 0, 2'b00, 1, 5'd6, 64'h3, 64'h00000000_80000000, 64'h0);
    tick();
    chk_out("ldb_s", 64'hFFFFFFFF_FFFFFF80, 5'd6, 1, 1, 0);
    chk_cnt("ldb_s", 32'd1);

    // signed half load, offset 6
    drive(1, 1, 1, 0, 2'b01, 1, 5'd7, 64'h6, 64'h8001_0000_0000_0000, 64'h0);
    tick();
    chk_out("ldh_s", 64'hFFFFFFFF_FFFF8001, 5'd7, 1, 1, 0);
    chk_cnt("ldh_s", 32'd2);

    // unsigned word load, offset 4
    drive(1, 1, 1, 0, 2'b10, 0, 5'd8, 64'h1004, 64'hDEADBEEF_00000000, 64'h0);
    tick();
    chk_out("ldw_u", 64'h00000000_DEADBEEF, 5'd8, 1, 1, 0);
    chk_cnt("ldw_u", 32'd3);

    // misaligned word load, offset 2
    drive(1, 1, 1, 0, 2'b10, 0, 5'd7, 64'h2, 64'h0, 64'h0);
    tick();
    chk_ctl("ldw_mis", 0, 1, 1);
    chk_cnt("ldw_mis", 32'd4);

    // bubble with write-enable asserted
    drive(0, 1, 0, 0, 2'b00, 0, 5'd4, 64'h55, 64'h0, 64'h0);
    tick();
    chk_ctl("bubble", 0, 0, 0);
    chk_cnt("bubble", 32'd4);

    // aligned dword load
    drive(1, 1, 1, 0, 2'b11, 0, 5'd2, 64'h0, 64'h01234567_89ABCDEF, 64'h0);
    tick();
    chk_out("ldd", 64'h01234567_89ABCDEF, 5'd2, 1, 1, 0);
    chk_cnt("ldd", 32'd4);

    // misaligned half load, offset 1
    drive(1, 1, 1, 0, 2'b01, 1, 5'd2, 64'h1, 64'hFFFF, 64'h0);
    tick();
    chk_ctl("ldh_mis", 0, 1, 1);
    chk_cnt("ldh_mis", 32'd5);

    // BL to X30 (Branchlink beats MemtoReg), then to XZR
    drive(1, 1, 1, 1, 2'b11, 0, 5'd30, 64'h0, 64'hABCD, 64'h400);
    tick();
    chk_out("bl30", 64'h400, 5'd30, 1, 1, 0);
    chk_cnt("bl30", 32'd5);
    drive(1, 1, 0, 1, 2'b00, 0, 5'd31, 64'h0, 64'h0, 64'h400);
    tick();
    chk_out("bl31", 64'h400, 5'd31, 0, 1, 0);
    chk_cnt("bl31", 32'd6);

    // held ALU write, then stall for three edges with changing inputs
    drive(1, 1, 0, 0, 2'b00, 0, 5'd9, 64'hAAAA, 64'h0, 64'h0);
    tick();
    chk_out("pre_stall", 64'hAAAA, 5'd9, 1, 1, 0);
    chk_cnt("pre_stall", 32'd6);
    stall = 1'b1;
    drive(1, 1, 0, 0, 2'b00, 0, 5'd10, 64'hBBBB, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", 64'hAAAA, 5'd9, 1, 1, 0);
      chk_cnt("stall", 32'd6);
    end
    flush = 1'b1;
    tick();
    chk_ctl("stall_flush", 0, 0, 0);
    stall = 1'b0; flush = 1'b0;

    // asynchronous reset between edges
    drive(1, 1, 0, 0, 2'b00, 0, 5'd3, 64'h77, 64'h0, 64'h0);
    tick();
    chk_out("pre_rst", 64'h77, 5'd3, 1, 1, 0);
    #2 reset = 1'b0;
    #1;
    chk_out("async_rst", 64'h0, 5'd0, 0, 0, 0);
    chk_cnt("async_rst", 32'd0);
    tick();
    chk_out("rst_hold", 64'h0, 5'd0, 0, 0, 0);
    #2 reset = 1'b1;
    tick();
    chk_out("first_cap", 64'h77, 5'd3, 1, 1, 0);
    chk_cnt("first_cap", 32'd0);

    // counter wrap: preset to all-ones while a write is held
    drive(0, 0, 0, 0, 2'b00, 0, 5'd0, 64'h0, 64'h0, 64'h0);
    #1 force dut.r_cnt = 32'hFFFFFFFF;
    #1 release dut.r_cnt;
    tick();
    chk_cnt("wrap", 32'd0);
    chk_ctl("wrap", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
